// File: rtl/i2c_bus_arbiter_if.sv
// Bus bundle between the two I2C master engines and the arbiter: requests, grants, per-master
// pin controls and the shared bus view. The tri-state sda pin stays a plain inout on the arbiter.
interface i2c_bus_arbiter_if;
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] gnt;
    logic       m0_scl;
    logic       m0_sda_oe;
    logic       m0_sda_o;
    logic       m1_scl;
    logic       m1_sda_oe;
    logic       m1_sda_o;
    logic       sda_in;
    logic       busy;
    logic       timeout_err;
    logic       scl;

    modport master (
        output req, done, m0_scl, m0_sda_oe, m0_sda_o, m1_scl, m1_sda_oe, m1_sda_o,
        input  gnt, sda_in, busy, timeout_err, scl
    );

    modport slave (
        input  req, done, m0_scl, m0_sda_oe, m0_sda_o, m1_scl, m1_sda_oe, m1_sda_o,
        output gnt, sda_in, busy, timeout_err, scl
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C bus between two masters, with a bus-free guard gap.
// Optional grant timeout enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 240,
    parameter int unsigned TIMEOUT_CYCLES = 48_000_000
) (
    input  logic              clk,
    input  logic              reset,
    i2c_bus_arbiter_if.slave  bus,
    inout  wire               sda
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, GUARD} state_t;

    localparam int GW = $clog2(GUARD_CYCLES + 1);

    if (GUARD_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("i2c_bus_arbiter: GUARD_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_gnt;
    logic            r_last;
    logic            w_last_nxt;
    logic [GW-1:0]   r_guard_cnt;
    logic [GW-1:0]   w_guard_cnt_nxt;
    logic            r_timeout_err;
    logic            w_timeout;
    logic            w_to_fire;
    logic            w_scl;
    logic            w_sda_oe;
    logic            w_sda_o;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYCLES - 1);

    logic [25:0] r_to_cnt;

    // Zero outside a grant, so every new grant starts counting from 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if ((r_state == GNT0 || r_state == GNT1) && w_state_nxt == r_state) begin
            r_to_cnt <= r_to_cnt + 26'd1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == GNT0 || r_state == GNT1) && (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_gnt         <= 2'b00;
            r_last        <= 1'b1;
            r_guard_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= {w_state_nxt == GNT1, w_state_nxt == GNT0};
            r_last        <= w_last_nxt;
            r_guard_cnt   <= w_guard_cnt_nxt;
            r_timeout_err <= w_to_fire;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_guard_cnt_nxt = r_guard_cnt;
        w_to_fire       = 1'b0;
        case (r_state)
            IDLE: begin
                w_guard_cnt_nxt = '0;
                if (bus.req == 2'b11) begin
                    w_state_nxt = r_last ? GNT0 : GNT1;
                end else if (bus.req[0]) begin
                    w_state_nxt = GNT0;
                end else if (bus.req[1]) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (bus.done[0] || !bus.req[0] || w_timeout) begin
                    w_state_nxt     = GUARD;
                    w_last_nxt      = 1'b0;
                    w_guard_cnt_nxt = '0;
                    // A done or release on the terminal cycle is a normal finish.
                    w_to_fire       = !(bus.done[0] || !bus.req[0]);
                end
            end
            GNT1: begin
                if (bus.done[1] || !bus.req[1] || w_timeout) begin
                    w_state_nxt     = GUARD;
                    w_last_nxt      = 1'b1;
                    w_guard_cnt_nxt = '0;
                    w_to_fire       = !(bus.done[1] || !bus.req[1]);
                end
            end
            GUARD: begin
                if (r_guard_cnt == GW'(GUARD_CYCLES - 1)) begin
                    w_state_nxt     = IDLE;
                    w_guard_cnt_nxt = '0;
                end else begin
                    w_guard_cnt_nxt = r_guard_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pin mux decodes the state register directly so an async reset frees the bus at once.
    always_comb begin
        w_scl    = 1'b1;
        w_sda_oe = 1'b0;
        w_sda_o  = 1'b1;
        case (r_state)
            GNT0: begin
                w_scl    = bus.m0_scl;
                w_sda_oe = bus.m0_sda_oe;
                w_sda_o  = bus.m0_sda_o;
            end
            GNT1: begin
                w_scl    = bus.m1_scl;
                w_sda_oe = bus.m1_sda_oe;
                w_sda_o  = bus.m1_sda_o;
            end
            default: ;
        endcase
    end

    assign sda             = w_sda_oe ? w_sda_o : 1'bz;
    assign bus.sda_in      = sda;
    assign bus.scl         = w_scl;
    assign bus.gnt         = r_gnt;
    assign bus.busy        = (r_state != IDLE);
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: expected grants are queued when stimulus is driven and
// compared (grant value, latency, guard busy cycles) when the arbiter issues the grant.
module tb_i2c_bus_arbiter;

    localparam int G      = 5;
    localparam int T      = 100;
    localparam int BUDGET = G + 20;

    typedef struct {
        logic [1:0] gnt;
        int         lat;
        int         busy_n;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tb_sda_oe = 1'b0;
    logic tb_sda_o = 1'b1;
    wire  sda;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    i2c_bus_arbiter_if bus_if ();

    i2c_bus_arbiter #(
        .GUARD_CYCLES   (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .sda   (sda)
    );

    // Open-drain style bus: another device may pull sda low; released bus floats high.
    pullup (sda);
    assign sda = tb_sda_oe ? tb_sda_o : 1'bz;

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void expect_grant(input logic [1:0] g, input int lat, input int busy_n);
        exp_t e;
        e.gnt    = g;
        e.lat    = lat;
        e.busy_n = busy_n;
        exp_q.push_back(e);
    endfunction

    // Waits for the next grant and compares it with the oldest queued expectation.
    task automatic wait_grant(input string tag);
        int   lat;
        int   busy_n;
        exp_t e;
        lat    = 0;
        busy_n = 0;
        if (bus_if.gnt == 2'b00 && bus_if.busy) busy_n++;
        while (bus_if.gnt == 2'b00 && lat < BUDGET) begin
            tick();
            lat++;
            if (bus_if.gnt == 2'b00 && bus_if.busy) busy_n++;
        end
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_gnt"}, 32'(bus_if.gnt), 32'(e.gnt));
            check({tag, "_latency"}, lat, e.lat);
            check({tag, "_guard_busy"}, busy_n, e.busy_n);
        end
    endtask

    task automatic masters_idle();
        bus_if.req       = 2'b00;
        bus_if.done      = 2'b00;
        bus_if.m0_scl    = 1'b1;
        bus_if.m0_sda_oe = 1'b0;
        bus_if.m0_sda_o  = 1'b1;
        bus_if.m1_scl    = 1'b1;
        bus_if.m1_sda_oe = 1'b0;
        bus_if.m1_sda_o  = 1'b1;
    endtask

    initial begin
        int held;
        int to_seen;

        // ---------------- reset state ----------------
        masters_idle();
        reset = 1'b0;
        tick();
        tick();
        check("rst_gnt", 32'(bus_if.gnt), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_scl", 32'(bus_if.scl), 32'd1);
        check("rst_sda_released", 32'(sda), 32'd1);
        check("rst_timeout_err", 32'(bus_if.timeout_err), 32'd0);
        reset = 1'b1;
        tick();

        // ---------------- single request, done on grant edge ignored ----------------
        bus_if.req  = 2'b01;
        bus_if.done = 2'b01;
        tick();
        bus_if.done = 2'b00;
        check("t1_gnt_1clk", 32'(bus_if.gnt), 32'b01);
        check("t1_busy", 32'(bus_if.busy), 32'd1);
        tick();
        check("t1_done_on_grant_ignored", 32'(bus_if.gnt), 32'b01);

        bus_if.m0_scl = 1'b0;
        #1 check("t1_scl_low", 32'(bus_if.scl), 32'd0);
        bus_if.m0_scl = 1'b1;
        #1 check("t1_scl_high", 32'(bus_if.scl), 32'd1);
        bus_if.m0_sda_oe = 1'b1;
        bus_if.m0_sda_o  = 1'b0;
        #1 check("t1_sda_drive0", 32'(sda), 32'd0);
        check("t1_sda_in0", 32'(bus_if.sda_in), 32'd0);
        bus_if.m0_sda_o = 1'b1;
        #1 check("t1_sda_drive1", 32'(sda), 32'd1);
        tick();
        bus_if.m0_sda_oe = 1'b0;
        tb_sda_oe = 1'b1;
        tb_sda_o  = 1'b0;
        #1 check("t1_sda_in_slave_low", 32'(bus_if.sda_in), 32'd0);
        tb_sda_oe = 1'b0;
        #1 check("t1_sda_in_released", 32'(bus_if.sda_in), 32'd1);

        // ---------------- other master requests mid-transfer ----------------
        bus_if.req    = 2'b11;
        bus_if.m1_scl = 1'b0;
        tick();
        tick();
        tick();
        check("t3_gnt_kept", 32'(bus_if.gnt), 32'b01);
        check("t3_m1_scl_blocked", 32'(bus_if.scl), 32'd1);
        tb_sda_oe = 1'b1;
        #1 check("t3_sda_in_valid", 32'(bus_if.sda_in), 32'd0);
        tb_sda_oe = 1'b0;
        bus_if.m1_scl = 1'b1;
        tick();

        // ---------------- done[0] and req[0] drop together ----------------
        expect_grant(2'b10, G + 1, G);
        bus_if.done = 2'b01;
        bus_if.req  = 2'b10;
        tick();
        bus_if.done = 2'b00;
        check("t6_gnt_dropped", 32'(bus_if.gnt), 32'd0);
        bus_if.req  = 2'b11;  // master 0 re-requests during the guard gap
        wait_grant("t6_next_m1");

        expect_grant(2'b01, G + 1, G);
        bus_if.req = 2'b01;   // master 1 releases by dropping req
        tick();
        wait_grant("t6_back_m0");
        bus_if.done = 2'b01;
        bus_if.req  = 2'b00;
        tick();
        bus_if.done = 2'b00;

        // ---------------- both request from reset, round robin ----------------
        reset = 1'b0;
        masters_idle();
        bus_if.req = 2'b11;
        tick();
        reset = 1'b1;
        expect_grant(2'b01, 1, 0);
        wait_grant("t2_first_m0");
        expect_grant(2'b10, G + 1, G);
        bus_if.done = 2'b01;
        tick();
        bus_if.done = 2'b00;
        wait_grant("t2_rr_m1");

        // ---------------- async reset while master 1 drives the bus ----------------
        bus_if.m1_scl    = 1'b0;
        bus_if.m1_sda_oe = 1'b1;
        bus_if.m1_sda_o  = 1'b0;
        #1 check("t4_m1_scl_on_bus", 32'(bus_if.scl), 32'd0);
        check("t4_m1_sda_on_bus", 32'(sda), 32'd0);
        #2 reset = 1'b0;
        #1 check("t4_rst_gnt", 32'(bus_if.gnt), 32'd0);
        check("t4_rst_scl", 32'(bus_if.scl), 32'd1);
        check("t4_rst_sda_released", 32'(sda), 32'd1);
        check("t4_rst_busy", 32'(bus_if.busy), 32'd0);
        masters_idle();
        tick();
        tick();
        reset = 1'b1;
        tick();

        // ---------------- grant timeout ----------------
        expect_grant(2'b01, 1, 0);
        bus_if.req = 2'b01;
        wait_grant("t5_grant_m0");
        bus_if.req = 2'b11;
        held    = 0;
        to_seen = 0;
        while (bus_if.gnt == 2'b01 && held < 3 * T) begin
            tick();
            held++;
            if (bus_if.timeout_err) to_seen++;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        check("t5_held_cycles", held, T);
        check("t5_gnt_dropped", 32'(bus_if.gnt), 32'd0);
        check("t5_timeout_err_pulse", 32'(bus_if.timeout_err), 32'd1);
        tick();
        check("t5_timeout_err_1clk", 32'(bus_if.timeout_err), 32'd0);
        expect_grant(2'b10, G, G - 1);
        wait_grant("t5_after_timeout_m1");
        bus_if.req = 2'b00;
        tick();
`else
        check("t5_held_cycles", held, 3 * T);
        check("t5_gnt_held", 32'(bus_if.gnt), 32'b01);
        check("t5_no_timeout_err", to_seen, 0);
        expect_grant(2'b10, G + 1, G);
        bus_if.done = 2'b01;
        bus_if.req  = 2'b10;
        tick();
        bus_if.done = 2'b00;
        wait_grant("t5_after_done_m1");
        bus_if.req = 2'b00;
        tick();
`endif
        check("end_sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
